// File: rtl/waveform_pixel_renderer.sv
// waveform_pixel_renderer
//
// Purpose:
//   Draws a multi-channel logic-analyzer waveform into the VGA pixel stream.
//   Each channel owns a horizontal lane of 2**LANE_H_LOG2 rows. Within a lane:
//     - a logic-1 sample is drawn on row HIGH_OFF;
//     - a logic-0 sample is drawn on row LOW_OFF;
//     - a vertical edge is drawn between those rows where the sample changes
//       from the previous column.
//   Optional overlays are a cursor column and a lane-separator grid.
//   The renderer is a two-stage pipeline, and the sync and video-active flags
//   are delayed by the same amount so that they stay aligned with rgb.
//
// Ports:
//   clk, reset    system clock; synchronous active-high reset
//   pixel_en      pixel strobe; every register advances only when it is high
//   hcount        raster column
//   vcount        raster row
//   video_on      active-area flag
//   hsync_in      sync from the timing generator
//   vsync_in      sync from the timing generator
//   sample        one stored sample bit per channel for column hcount
//   edge_en       enables drawing of vertical transition edges
//   grid_en       enables drawing of lane separators
//   cursor_en     enables drawing of the cursor column
//   cursor_x      cursor column
//   rgb           pixel colour
//   hsync_out     hsync_in delayed to match rgb
//   vsync_out     vsync_in delayed to match rgb
//   video_on_out  video_on delayed to match rgb
module waveform_pixel_renderer #(
  parameter int          NUM_CH      = 4,
  parameter int          H_W         = 10,
  parameter int          V_W         = 10,
  parameter int          TOP         = 48,
  parameter int          LANE_H_LOG2 = 6,
  parameter int          HIGH_OFF    = 16,
  parameter int          LOW_OFF     = 48,
  parameter logic [2:0]  TRACE_RGB   = 3'b010,
  parameter logic [2:0]  CURSOR_RGB  = 3'b100,
  parameter logic [2:0]  GRID_RGB    = 3'b001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_en,
  input  logic [H_W-1:0]    hcount,
  input  logic [V_W-1:0]    vcount,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [NUM_CH-1:0] sample,
  input  logic              edge_en,
  input  logic              grid_en,
  input  logic              cursor_en,
  input  logic [H_W-1:0]    cursor_x,
  output logic [2:0]        rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_on_out
);

  // Stage-1 combinational decode
  logic [V_W-1:0]         rel;
  logic [V_W-1:0]         lane;
  logic [LANE_H_LOG2-1:0] off;
  logic                   in_lanes;
  logic                   cur_bit;
  logic                   prev_bit;
  logic                   first_eff;
  logic                   edge_hit;
  logic                   cursor_hit;

  // Column-to-column history used for edge detection
  logic [NUM_CH-1:0]      prev_sample;
  logic                   first_col;

  // Stage-1 registers
  logic [LANE_H_LOG2-1:0] s1_off;
  logic                   s1_in_lanes;
  logic                   s1_bit;
  logic                   s1_edge;
  logic                   s1_cursor;
  logic                   s1_video_on;
  logic                   s1_hsync;
  logic                   s1_vsync;

  // Stage-2 colour decision
  logic [2:0]             rgb_next;

  // Lane decode. Rows above TOP wrap rel to a large value, which lands
  // outside every lane, so no channel matches and the row stays blank.
  // Column 0 is treated as a first column even without preceding blanking,
  // so a line wrap can never draw an edge at the left border.
  always_comb begin
    rel       = vcount - V_W'(TOP);
    lane      = rel >> LANE_H_LOG2;
    off       = rel[LANE_H_LOG2-1:0];
    in_lanes  = (vcount >= V_W'(TOP)) && (lane < V_W'(NUM_CH));
    cur_bit   = 1'b0;
    prev_bit  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lane == V_W'(i)) begin
        cur_bit  = sample[i];
        prev_bit = prev_sample[i];
      end
    end
    first_eff  = first_col || (hcount == '0);
    edge_hit   = edge_en && !first_eff && (cur_bit != prev_bit) &&
                 (off >= LANE_H_LOG2'(HIGH_OFF)) && (off <= LANE_H_LOG2'(LOW_OFF));
    cursor_hit = cursor_en && (hcount == cursor_x);
  end

  // Sample history. Blanking marks the next active column as the first one,
  // so the last column of a line never forms an edge with the next line.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample <= '0;
      first_col   <= 1'b1;
    end else if (pixel_en) begin
      if (video_on) begin
        prev_sample <= sample;
        first_col   <= 1'b0;
      end else begin
        first_col   <= 1'b1;
      end
    end
  end

  // Stage-1 pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_off      <= '0;
      s1_in_lanes <= 1'b0;
      s1_bit      <= 1'b0;
      s1_edge     <= 1'b0;
      s1_cursor   <= 1'b0;
      s1_video_on <= 1'b0;
      s1_hsync    <= 1'b0;
      s1_vsync    <= 1'b0;
    end else if (pixel_en) begin
      s1_off      <= off;
      s1_in_lanes <= in_lanes;
      s1_bit      <= cur_bit;
      s1_edge     <= edge_hit;
      s1_cursor   <= cursor_hit;
      s1_video_on <= video_on;
      s1_hsync    <= hsync_in;
      s1_vsync    <= vsync_in;
    end
  end

  // Colour priority: blanking, then cursor, then trace/edge, then grid.
  always_comb begin
    rgb_next = 3'b000;
    if (!s1_video_on) begin
      rgb_next = 3'b000;
    end else if (s1_cursor) begin
      rgb_next = CURSOR_RGB;
    end else if (s1_in_lanes &&
                 ((s1_bit && (s1_off == LANE_H_LOG2'(HIGH_OFF))) ||
                  (!s1_bit && (s1_off == LANE_H_LOG2'(LOW_OFF))) ||
                  s1_edge)) begin
      rgb_next = TRACE_RGB;
    end else if (s1_in_lanes && grid_en && (s1_off == '0)) begin
      rgb_next = GRID_RGB;
    end
  end

  // Stage-2 output register
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb          <= 3'b000;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
    end else if (pixel_en) begin
      rgb          <= rgb_next;
      hsync_out    <= s1_hsync;
      vsync_out    <= s1_vsync;
      video_on_out <= s1_video_on;
    end
  end

endmodule

// File: tb/tb_waveform_pixel_renderer.sv
// tb_waveform_pixel_renderer
//
// Purpose:
//   Self-checking bench for waveform_pixel_renderer. Each pixel strobe pushes
//   the expected {rgb, hsync, vsync, video_on} word, computed by a small
//   reference model, into a scoreboard queue. Once the two-stage pipeline is
//   full, the oldest entry is popped on every strobe and compared against the
//   DUT outputs.
//
// Ports: none (top-level bench).
module tb_waveform_pixel_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_en = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       video_on = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [3:0] sample = '0;
  logic       edge_en = 1'b0;
  logic       grid_en = 1'b0;
  logic       cursor_en = 1'b0;
  logic [9:0] cursor_x = '0;
  logic [2:0] rgb;
  logic       hsync_out;
  logic       vsync_out;
  logic       video_on_out;

  int total = 0;
  int bad = 0;

  logic [5:0] sb[$];
  logic [3:0] m_prev = '0;
  bit         m_first = 1'b1;

  wire  [5:0] obs = {rgb, hsync_out, vsync_out, video_on_out};

  waveform_pixel_renderer #(
    .NUM_CH(4), .H_W(10), .V_W(10), .TOP(48), .LANE_H_LOG2(6),
    .HIGH_OFF(16), .LOW_OFF(48),
    .TRACE_RGB(3'b010), .CURSOR_RGB(3'b100), .GRID_RGB(3'b001)
  ) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .sample(sample),
    .edge_en(edge_en), .grid_en(grid_en), .cursor_en(cursor_en),
    .cursor_x(cursor_x), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .video_on_out(video_on_out)
  );

  always #5 clk = ~clk;

  // Reference pixel for the current inputs and model history.
  function automatic logic [5:0] model_px();
    logic [9:0] rel;
    logic [9:0] lane;
    logic [5:0] off;
    logic       in_l, b, pb, edg, first;
    logic [2:0] c;
    rel   = vcount - 10'd48;
    lane  = rel >> 6;
    off   = rel[5:0];
    in_l  = (vcount >= 10'd48) && (lane < 10'd4);
    b     = in_l ? sample[lane[1:0]] : 1'b0;
    pb    = in_l ? m_prev[lane[1:0]] : 1'b0;
    first = m_first || (hcount == 10'd0);
    edg   = edge_en && !first && (b != pb) && (off >= 6'd16) && (off <= 6'd48);
    if (!video_on)                                   c = 3'b000;
    else if (cursor_en && (hcount == cursor_x))      c = 3'b100;
    else if (in_l && ((b && off == 6'd16) || (!b && off == 6'd48) || edg))
                                                     c = 3'b010;
    else if (in_l && grid_en && off == 6'd0)         c = 3'b001;
    else                                             c = 3'b000;
    return {c, hsync_in, vsync_in, video_on};
  endfunction

  // One pixel strobe: pushes the expected word, advances the model history,
  // and pops the entry whose result the DUT is now presenting.
  task automatic strobe(output bit have, output logic [5:0] want);
    logic [5:0] e;
    e = model_px();
    pixel_en = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(e);
    if (video_on) begin
      m_prev  = sample;
      m_first = 1'b0;
    end else begin
      m_first = 1'b1;
    end
    have = 1'b0;
    want = '0;
    if (sb.size() > 1) begin
      want = sb.pop_front();
      have = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit hv;
    logic [5:0] w;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pixel_en = 1'b1;
      video_on = 1'b1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      hcount   = 10'($urandom_range(0, 639));
      vcount   = 10'd64;
      sample   = 4'($urandom);
      cursor_en = 1'b1;
      cursor_x = hcount;
      @(posedge clk);
      #1;
      total++;
      if (obs !== 6'b0) begin
        bad++;
        $display("[TB] FAIL reset_hold cycle=%0d got=%b want=%b", i, obs, 6'b0);
      end
    end
    cursor_en = 1'b0;
    reset = 1'b0;
    sb.delete();
    m_prev = '0;
    m_first = 1'b1;
    video_on = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe(hv, w);
      total++;
      if (rgb !== 3'b000) begin
        bad++;
        $display("[TB] FAIL reset_release_rgb i=%0d got=%b want=000", i, rgb);
      end
      if (hv) begin
        total++;
        if (obs !== w) begin
          bad++;
          $display("[TB] FAIL reset_release i=%0d got=%b want=%b", i, obs, w);
        end
      end
    end
  endtask

  task automatic test_trace();
    bit hv;
    logic [5:0] w;
    logic [9:0] rows[3] = '{10'd64, 10'd96, 10'd160};
    logic [9:0] last[3] = '{10'd639, 10'd63, 10'd63};
    sample = 4'b0001;
    for (int r = 0; r < 3; r++) begin
      vcount = rows[r];
      for (int h = 0; h <= int'(last[r]); h++) begin
        video_on = 1'b1;
        hcount = 10'(h);
        hsync_in = (h % 16) == 3;
        vsync_in = (h % 32) == 7;
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL trace v=%0d h=%0d got=%b want=%b", vcount, h, obs, w);
          end
        end
      end
      video_on = 1'b0;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL trace_blank i=%0d got=%b want=%b", i, obs, w);
          end
        end
      end
    end
  endtask

  task automatic test_edge();
    bit hv;
    logic [5:0] w;
    logic [9:0] rows[3] = '{10'd80, 10'd80, 10'd100};
    bit         ens[3]  = '{1'b1, 1'b0, 1'b1};
    for (int r = 0; r < 3; r++) begin
      vcount = rows[r];
      edge_en = ens[r];
      for (int h = 90; h < 110; h++) begin
        video_on = 1'b1;
        hcount = 10'(h);
        sample = {3'b101, h >= 100};
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL edge v=%0d en=%0d h=%0d got=%b want=%b", vcount, edge_en, h, obs, w);
          end
        end
      end
      video_on = 1'b0;
      for (int i = 0; i < 2; i++) begin
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL edge_blank i=%0d got=%b want=%b", i, obs, w);
          end
        end
      end
    end
    edge_en = 1'b0;
  endtask

  task automatic test_cursor();
    bit hv;
    logic [5:0] w;
    logic [9:0] rows[2] = '{10'd64, 10'd20};
    cursor_en = 1'b1;
    cursor_x = 10'd200;
    sample = 4'b0001;
    for (int r = 0; r < 2; r++) begin
      vcount = rows[r];
      for (int h = 195; h < 206; h++) begin
        video_on = 1'b1;
        hcount = 10'(h);
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL cursor v=%0d h=%0d got=%b want=%b", vcount, h, obs, w);
          end
        end
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_grid();
    bit hv;
    logic [5:0] w;
    logic [9:0] rows[3] = '{10'd112, 10'd40, 10'd304};
    grid_en = 1'b1;
    sample = 4'b0000;
    for (int r = 0; r < 3; r++) begin
      vcount = rows[r];
      for (int h = 10; h < 20; h++) begin
        video_on = 1'b1;
        hcount = 10'(h);
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL grid v=%0d h=%0d got=%b want=%b", vcount, h, obs, w);
          end
        end
      end
    end
    grid_en = 1'b0;
  endtask

  // End of one line samples 1, start of the next samples 0 on the edge row;
  // tried both with blanking in between and with a direct wrap.
  task automatic test_line_wrap();
    bit hv;
    logic [5:0] w;
    edge_en = 1'b1;
    vcount = 10'd80;
    for (int pass = 0; pass < 2; pass++) begin
      for (int h = 630; h < 644; h++) begin
        video_on = (h < 640) || (pass == 1);
        if (h >= 640 && pass == 1) break;
        hcount = 10'(h % 640);
        sample = 4'b1111;
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL wrap_tail p=%0d h=%0d got=%b want=%b", pass, h, obs, w);
          end
        end
      end
      for (int h = 0; h < 4; h++) begin
        video_on = 1'b1;
        hcount = 10'(h);
        sample = 4'b0000;
        strobe(hv, w);
        if (hv) begin
          total++;
          if (obs !== w) begin
            bad++;
            $display("[TB] FAIL wrap_head p=%0d h=%0d got=%b want=%b", pass, h, obs, w);
          end
        end
      end
    end
    edge_en = 1'b0;
  endtask

  task automatic test_pixel_en();
    bit hv;
    logic [5:0] w;
    logic [5:0] held;
    edge_en = 1'b1;
    vcount = 10'd80;
    for (int h = 0; h < 24; h++) begin
      video_on = 1'b1;
      hcount = 10'(h);
      sample = {3'b000, (h % 5) < 2};
      hsync_in = h[0];
      vsync_in = h[1];
      strobe(hv, w);
      if (hv) begin
        total++;
        if (obs !== w) begin
          bad++;
          $display("[TB] FAIL strobe_seq h=%0d got=%b want=%b", h, obs, w);
        end
      end
      held = obs;
      pixel_en = 1'b0;
      hcount = 10'($urandom_range(0, 639));
      sample = 4'($urandom);
      hsync_in = ~hsync_in;
      video_on = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (obs !== held) begin
        bad++;
        $display("[TB] FAIL strobe_hold h=%0d got=%b want=%b", h, obs, held);
      end
    end
    edge_en = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hv;
    logic [5:0] w;
    edge_en = 1'b1;
    vcount = 10'd80;
    video_on = 1'b1;
    for (int h = 40; h < 50; h++) begin
      hcount = 10'(h);
      sample = 4'b0000;
      strobe(hv, w);
      if (hv) begin
        total++;
        if (obs !== w) begin
          bad++;
          $display("[TB] FAIL mid_pre h=%0d got=%b want=%b", h, obs, w);
        end
      end
    end
    reset = 1'b1;
    pixel_en = 1'b1;
    hcount = 10'd50;
    @(posedge clk);
    #1;
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset got=%b want=%b", obs, 6'b0);
    end
    reset = 1'b0;
    sb.delete();
    m_prev = '0;
    m_first = 1'b1;
    for (int h = 51; h < 60; h++) begin
      hcount = 10'(h);
      sample = 4'b0001;
      strobe(hv, w);
      if (h == 51) begin
        total++;
        if (rgb !== 3'b000) begin
          bad++;
          $display("[TB] FAIL mid_flush got=%b want=000", rgb);
        end
      end
      if (hv) begin
        total++;
        if (obs !== w) begin
          bad++;
          $display("[TB] FAIL mid_post h=%0d got=%b want=%b", h, obs, w);
        end
      end
    end
    edge_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trace();
    test_edge();
    test_cursor();
    test_grid();
    test_line_wrap();
    test_pixel_en();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
